// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and burst default for the memory arbiter.
package arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CORE = 2'b01,
        DMA  = 2'b10
    } arb_state_e;
    localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/arb_fsm.sv
// arb_fsm: grant selection between core and DMA with locked DMA bursts.
module arb_fsm
    import arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic c_req,
    input  logic d_req,
    input  logic d_lock,
    output logic c_gnt,
    output logic d_gnt
);
    localparam int BW = $clog2(MAX_BURST + 1);
    arb_state_e state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic dma_wins;
    // dma_wins only matters when both request; a lone requester always wins
    always_comb begin
        dma_wins = (state_q == CORE) || (state_q == DMA && d_lock && burst_q < BW'(MAX_BURST));
        d_gnt = ~reset & d_req & (~c_req | dma_wins);
        c_gnt = ~reset & c_req & ~d_gnt;
        state_d = c_gnt ? CORE : d_gnt ? DMA : IDLE;
        burst_d = ~d_gnt ? '0 : (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between core and DMA.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [31:0]   c_wd,
    output logic          c_gnt,
    output logic          c_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [31:0]   d_wd,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [31:0]   rd,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd,
    output logic          stall
);
    logic c_valid_q, c_valid_d, d_valid_q, d_valid_d;
    arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
        .clk   (clk),
        .reset (reset),
        .c_req (c_req),
        .d_req (d_req),
        .d_lock(d_lock),
        .c_gnt (c_gnt),
        .d_gnt (d_gnt)
    );
    // valids are masked during reset so a read granted just before reset never reports
    always_comb begin
        mem_en    = c_gnt | d_gnt;
        mem_we    = c_gnt ? c_we : d_gnt ? d_we : 1'b0;
        mem_adr   = c_gnt ? c_adr : d_gnt ? d_adr : '0;
        mem_wd    = c_gnt ? c_wd : d_gnt ? d_wd : '0;
        c_valid_d = c_gnt & ~c_we;
        d_valid_d = d_gnt & ~d_we;
        c_valid   = c_valid_q & ~reset;
        d_valid   = d_valid_q & ~reset;
        stall     = c_req & ~c_gnt & ~reset;
        rd        = mem_rd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            c_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            c_valid_q <= c_valid_d;
            d_valid_q <= d_valid_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed sequences and a randomized reference-model run.
module tb_mem_arbiter;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic reset, c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_adr, c_wd, d_adr, d_wd, mem_adr, mem_wd, mem_rd, rd;
    logic c_gnt, c_valid, d_gnt, d_valid, mem_en, mem_we, stall;
    logic [31:0] ram [256];
    logic fill;
    int errors = 0, checks = 0;

    mem_arbiter #(.MAX_BURST(MB), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd), .c_gnt(c_gnt), .c_valid(c_valid),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_valid(d_valid), .rd(rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        else if (mem_en) begin
            if (mem_we) ram[mem_adr[9:2]] <= mem_wd;
            else mem_rd <= ram[mem_adr[9:2]];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic r, c, d, l, cg, dg, st;
    } vec_t;
    vec_t tv[17];

    function automatic vec_t mk(logic r, logic c, logic d, logic l, logic cg, logic dg, logic st);
        vec_t v;
        v.r = r; v.c = c; v.d = d; v.l = l; v.cg = cg; v.dg = dg; v.st = st;
        return v;
    endfunction

    int hist[$];
    logic pcv, pdv;
    logic [31:0] prd;

    function automatic int trailing_dma();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0 && n < MB; i--) begin
            if (hist[i] != 2) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        bit cp, dp;
        int w, last;
        reset = 1; fill = 1;
        c_req = 0; c_we = 0; c_adr = 0; c_wd = 0;
        d_req = 0; d_we = 0; d_adr = 0; d_wd = 0; d_lock = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); fill = 0;
        #1;
        chk("reset c_valid", c_valid, 0);
        chk("reset stall", stall, 0);
        // lone core read of 0x10
        @(negedge clk); reset = 0; c_req = 1; c_we = 0; c_adr = 32'h10;
        #1;
        chk("rd10 c_gnt", c_gnt, 1);
        chk("rd10 stall", stall, 0);
        chk("rd10 mem_adr", mem_adr, 32'h10);
        @(negedge clk); c_req = 0;
        #1;
        chk("rd10 c_valid", c_valid, 1);
        chk("rd10 rd", rd, init_val(4));
        // DMA write then core read-back
        @(negedge clk); d_req = 1; d_we = 1; d_adr = 32'h20; d_wd = 32'hDEADBEEF;
        #1;
        chk("dwr d_gnt", d_gnt, 1);
        chk("dwr mem_we", mem_we, 1);
        chk("dwr mem_wd", mem_wd, 32'hDEADBEEF);
        @(negedge clk); d_req = 0; d_we = 0; c_req = 1; c_we = 0; c_adr = 32'h20;
        #1;
        chk("crd c_gnt", c_gnt, 1);
        chk("crd mem_we", mem_we, 0);
        chk("crd d_valid", d_valid, 0);
        @(negedge clk); c_req = 0;
        #1;
        chk("crd c_valid", c_valid, 1);
        chk("crd rd", rd, 32'hDEADBEEF);
        // reset right after a core read grant
        @(negedge clk); c_req = 1; c_adr = 32'h30;
        #1;
        chk("rstrd c_gnt", c_gnt, 1);
        @(negedge clk); reset = 1; d_req = 1;
        #1;
        chk("rstrd c_valid", c_valid, 0);
        chk("rstrd c_gnt", c_gnt, 0);
        chk("rstrd d_gnt", d_gnt, 0);
        chk("rstrd mem_en", mem_en, 0);
        chk("rstrd stall", stall, 0);
        @(negedge clk); reset = 0;
        #1;
        chk("post c_gnt", c_gnt, 1);
        chk("post d_gnt", d_gnt, 0);
        // grant-order table: reset, idle, round robin, locked burst, deasserted requests
        tv[0]  = mk(1, 1, 1, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 0, 0, 1, 0, 0);
        tv[2]  = mk(0, 1, 1, 0, 0, 1, 1);
        tv[3]  = mk(0, 1, 1, 0, 1, 0, 0);
        tv[4]  = mk(0, 0, 0, 0, 0, 0, 0);
        tv[5]  = mk(0, 1, 1, 1, 1, 0, 0);
        tv[6]  = mk(0, 1, 1, 1, 0, 1, 1);
        tv[7]  = mk(0, 1, 1, 1, 0, 1, 1);
        tv[8]  = mk(0, 1, 1, 1, 0, 1, 1);
        tv[9]  = mk(0, 1, 1, 1, 0, 1, 1);
        tv[10] = mk(0, 1, 1, 1, 1, 0, 0);
        tv[11] = mk(0, 0, 1, 1, 0, 1, 0);
        tv[12] = mk(0, 0, 0, 1, 0, 0, 0);
        tv[13] = mk(0, 0, 1, 0, 0, 1, 0);
        tv[14] = mk(0, 0, 0, 0, 0, 0, 0);
        tv[15] = mk(0, 1, 0, 0, 1, 0, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset = tv[i].r; c_req = tv[i].c; d_req = tv[i].d; d_lock = tv[i].l;
            c_we = 0; d_we = 0;
            #1;
            chk($sformatf("tv%0d c_gnt", i), c_gnt, tv[i].cg);
            chk($sformatf("tv%0d d_gnt", i), d_gnt, tv[i].dg);
            chk($sformatf("tv%0d stall", i), stall, tv[i].st);
            chk($sformatf("tv%0d mem_en", i), mem_en, tv[i].cg | tv[i].dg);
        end
        // randomized traffic against the reference model
        cp = 0; dp = 0; pcv = 0; pdv = 0; prd = 0;
        hist.delete();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = (n == 0) || ($urandom_range(0, 149) == 0);
            if (!cp) begin
                c_req = ($urandom_range(0, 2) != 0); c_we = $urandom_range(0, 1) == 1;
                c_adr = 32'($urandom_range(0, 255)) << 2; c_wd = $urandom; cp = c_req;
            end
            if (!dp) begin
                d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
                d_adr = 32'($urandom_range(0, 255)) << 2; d_wd = $urandom; dp = d_req;
            end
            d_lock = $urandom_range(0, 3) != 0;
            #1;
            last = hist.size() > 0 ? hist[hist.size() - 1] : 0;
            w = 0;
            if (!reset) begin
                if (c_req && d_req)
                    w = (last == 1) ? 2 : (last == 2 && d_lock && trailing_dma() < MB) ? 2 : 1;
                else if (c_req) w = 1;
                else if (d_req) w = 2;
            end
            chk("rnd c_gnt", c_gnt, w == 1);
            chk("rnd d_gnt", d_gnt, w == 2);
            chk("rnd stall", stall, c_req && !reset && w != 1);
            chk("rnd mem_en", mem_en, w != 0);
            chk("rnd mem_we", mem_we, w == 1 ? c_we : w == 2 ? d_we : 1'b0);
            chk("rnd mem_adr", mem_adr, w == 1 ? c_adr : w == 2 ? d_adr : 32'h0);
            chk("rnd mem_wd", mem_wd, w == 1 ? c_wd : w == 2 ? d_wd : 32'h0);
            chk("rnd c_valid", c_valid, pcv && !reset);
            chk("rnd d_valid", d_valid, pdv && !reset);
            if ((pcv || pdv) && !reset) chk("rnd rd", rd, prd);
            if (reset) begin
                hist.delete(); pcv = 0; pdv = 0;
            end else begin
                hist.push_back(w);
                if (hist.size() > 8) void'(hist.pop_front());
                pcv = (w == 1) && !c_we;
                pdv = (w == 2) && !d_we;
                prd = (w == 1) ? ram[c_adr[9:2]] : ram[d_adr[9:2]];
                if (w == 1) cp = 0;
                if (w == 2) dp = 0;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
